// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM
// stage and a combinational main memory, with saturating load hit/miss counters.
module data_cache #(
   parameter int LINES   = 16,
   parameter int INDEX_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic        MemWriteM,
   input  logic        MemReadM,
   input  logic        FlushC,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   output logic        MemWrite,
   input  logic [31:0] MemRData,
   output logic [31:0] HitCount,
   output logic [31:0] MissCount
);

   localparam int TAG_W = 32 - INDEX_W - 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [LINES-1:0]   r_valid;
   logic [TAG_W-1:0]   r_tag  [LINES];
   logic [31:0]        r_data [LINES];
   logic [31:0]        r_mem_addr;
   logic [31:0]        r_mem_wdata;
   logic               r_mem_write;
   logic [31:0]        r_hit_cnt;
   logic [31:0]        r_miss_cnt;

   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_hit;
   logic [INDEX_W-1:0] w_midx;
   logic [TAG_W-1:0]   w_mtag;
   logic               w_mhit;
   logic               w_stall;
   logic [31:0]        w_rdata;
   logic               w_load_hit;
   logic               w_load_miss;
   logic               w_store_req;

   assign w_idx  = ALUOutM[INDEX_W+1:2];
   assign w_tag  = ALUOutM[31:INDEX_W+2];
   assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_midx = r_mem_addr[INDEX_W+1:2];
   assign w_mtag = r_mem_addr[31:INDEX_W+2];
   assign w_mhit = r_valid[w_midx] && (r_tag[w_midx] == w_mtag);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and pipeline-facing outputs
   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      w_rdata      = 32'd0;
      w_load_hit   = 1'b0;
      w_load_miss  = 1'b0;
      w_store_req  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (MemWriteM) begin
               w_stall      = 1'b1;
               w_store_req  = 1'b1;
               w_next_state = S_WRITE;
            end else if (MemReadM) begin
               if (w_hit) begin
                  w_rdata    = r_data[w_idx];
                  w_load_hit = 1'b1;
               end else begin
                  w_stall      = 1'b1;
                  w_load_miss  = 1'b1;
                  w_next_state = S_FILL;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_FILL: begin
            w_rdata      = MemRData;
            w_next_state = S_IDLE;
         end
         S_WRITE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Gated so a request held across reset cannot stall or return stale data
   assign StallM    = w_stall & rst_n;
   assign ReadDataM = rst_n ? w_rdata : 32'd0;

   // Memory-side request registers: only ever change on a clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_write <= 1'b0;
      end else if (w_store_req) begin
         r_mem_addr  <= ALUOutM;
         r_mem_wdata <= WriteDataM;
         r_mem_write <= 1'b1;
      end else if (w_load_miss) begin
         r_mem_addr  <= ALUOutM;
         r_mem_write <= 1'b0;
      end else begin
         r_mem_write <= 1'b0;
      end
   end

   // Valid bits; flush wins over a fill landing on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= {LINES{1'b0}};
      end else if (FlushC) begin
         r_valid <= {LINES{1'b0}};
      end else if (r_state == S_FILL) begin
         r_valid[w_midx] <= 1'b1;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Tag/data arrays; a store only refreshes a line it already owns
   always_ff @(posedge clk) begin
      if (r_state == S_FILL) begin
         r_tag[w_midx]  <= w_mtag;
         r_data[w_midx] <= MemRData;
      end else if ((r_state == S_WRITE) && w_mhit) begin
         r_data[w_midx] <= r_mem_wdata;
      end
   end

   // Saturating load hit/miss counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt  <= 32'd0;
         r_miss_cnt <= 32'd0;
      end else begin
         if (w_load_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_load_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign MemAddr   = r_mem_addr;
   assign MemWData  = r_mem_wdata;
   assign MemWrite  = r_mem_write;
   assign HitCount  = r_hit_cnt;
   assign MissCount = r_miss_cnt;

endmodule

// File: tb/tb_data_cache.sv
// Directed plus randomized bench for data_cache against a transaction-level
// cache/memory reference model and a combinational memory environment.
module tb_data_cache;

   logic        clk;
   logic        rst_n;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic        MemWriteM;
   logic        MemReadM;
   logic        FlushC;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic        MemWrite;
   logic [31:0] MemRData;
   logic [31:0] HitCount;
   logic [31:0] MissCount;

   int total;
   int bad;

   // environment memory: 64 words, byte addresses 0x00..0xFF
   logic [31:0] tb_mem [64];

   // reference model state
   logic [31:0] ref_mem   [64];
   logic        ref_valid [16];
   logic [31:0] ref_tag   [16];
   logic [31:0] ref_data  [16];
   logic [31:0] ref_hits;
   logic [31:0] ref_miss;

   data_cache #(.LINES(16), .INDEX_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
      .MemWriteM(MemWriteM), .MemReadM(MemReadM), .FlushC(FlushC),
      .ReadDataM(ReadDataM), .StallM(StallM), .MemAddr(MemAddr),
      .MemWData(MemWData), .MemWrite(MemWrite), .MemRData(MemRData),
      .HitCount(HitCount), .MissCount(MissCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign MemRData = tb_mem[MemAddr[7:2]];

   always @(posedge clk) begin
      if (MemWrite) tb_mem[MemAddr[7:2]] <= MemWData;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ref_reset();
      for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
      ref_hits = 32'd0;
      ref_miss = 32'd0;
   endtask

   task automatic do_load(input logic [31:0] a);
      int          idx;
      logic [31:0] tg;
      logic        exp_hit;
      logic [31:0] exp_data;
      idx = (a >> 2) % 16;
      tg  = a >> 6;
      exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
      if (exp_hit) begin
         exp_data = ref_data[idx];
         ref_hits = ref_hits + 32'd1;
      end else begin
         exp_data       = ref_mem[a[7:2]];
         ref_miss       = ref_miss + 32'd1;
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tg;
         ref_data[idx]  = exp_data;
      end
      @(posedge clk); #1;
      ALUOutM  = a;
      MemReadM = 1'b1;
      @(negedge clk);
      check("ld_stall_first", {31'd0, StallM}, exp_hit ? 32'd0 : 32'd1);
      if (!exp_hit) begin
         @(negedge clk);
         check("ld_stall_fill", {31'd0, StallM}, 32'd0);
      end
      check("ld_data", ReadDataM, exp_data);
      @(posedge clk); #1;
      MemReadM = 1'b0;
      check("ld_hitcnt", HitCount, ref_hits);
      check("ld_misscnt", MissCount, ref_miss);
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic both);
      int idx;
      idx = (a >> 2) % 16;
      ref_mem[a[7:2]] = d;
      if (ref_valid[idx] && (ref_tag[idx] == (a >> 6))) ref_data[idx] = d;
      @(posedge clk); #1;
      ALUOutM    = a;
      WriteDataM = d;
      MemWriteM  = 1'b1;
      MemReadM   = both;
      @(negedge clk);
      check("st_stall_first", {31'd0, StallM}, 32'd1);
      check("st_memwrite_idle", {31'd0, MemWrite}, 32'd0);
      @(negedge clk);
      check("st_stall_write", {31'd0, StallM}, 32'd0);
      check("st_memwrite_on", {31'd0, MemWrite}, 32'd1);
      check("st_memaddr", MemAddr, a);
      check("st_memwdata", MemWData, d);
      @(posedge clk); #1;
      MemWriteM = 1'b0;
      MemReadM  = 1'b0;
      check("st_memwrite_off", {31'd0, MemWrite}, 32'd0);
      check("st_mem_word", tb_mem[a[7:2]], d);
      check("st_hitcnt", HitCount, ref_hits);
      check("st_misscnt", MissCount, ref_miss);
   endtask

   task automatic do_flush();
      @(posedge clk); #1;
      FlushC = 1'b1;
      @(posedge clk); #1;
      FlushC = 1'b0;
      for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
   endtask

   initial begin
      logic [31:0] w;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      ALUOutM = 32'd0; WriteDataM = 32'd0;
      MemWriteM = 1'b0; MemReadM = 1'b0; FlushC = 1'b0;
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         if (i == 16) w = 32'hDEAD_BEEF;
         tb_mem[i]  <= w;
         ref_mem[i] = w;
      end
      ref_reset();
      #2;
      check("rst_readdata", ReadDataM, 32'd0);
      check("rst_stall", {31'd0, StallM}, 32'd0);
      check("rst_memaddr", MemAddr, 32'd0);
      check("rst_memwdata", MemWData, 32'd0);
      check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
      check("rst_hitcnt", HitCount, 32'd0);
      check("rst_misscnt", MissCount, 32'd0);
      #10 rst_n = 1'b1;

      // basic miss then hit, store-hit, store-miss, both-high store
      do_load(32'h40);
      do_load(32'h40);
      do_store(32'h40, 32'h1234_5678, 1'b0);
      do_load(32'h40);
      do_store(32'h80, 32'hA5A5_A5A5, 1'b0);
      do_load(32'h80);
      do_store(32'h84, 32'h0BAD_F00D, 1'b1);

      // conflict on index 0
      do_load(32'h00);
      do_load(32'h40);
      do_load(32'h00);

      // flush pulse then reload misses
      do_load(32'h40);
      do_flush();
      do_load(32'h40);

      // flush coincident with the fill edge
      do_flush();
      ref_miss = ref_miss + 32'd1;
      @(posedge clk); #1;
      ALUOutM  = 32'h44;
      MemReadM = 1'b1;
      @(negedge clk);
      check("ff_stall_first", {31'd0, StallM}, 32'd1);
      @(posedge clk); #1;
      FlushC = 1'b1;
      @(negedge clk);
      check("ff_data", ReadDataM, ref_mem[17]);
      check("ff_stall_fill", {31'd0, StallM}, 32'd0);
      @(posedge clk); #1;
      FlushC   = 1'b0;
      MemReadM = 1'b0;
      do_load(32'h44);

      // reset in the middle of a fill
      @(posedge clk); #1;
      ALUOutM  = 32'h48;
      MemReadM = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rf_memwrite", {31'd0, MemWrite}, 32'd0);
      check("rf_stall", {31'd0, StallM}, 32'd0);
      check("rf_readdata", ReadDataM, 32'd0);
      check("rf_hitcnt", HitCount, 32'd0);
      check("rf_misscnt", MissCount, 32'd0);
      MemReadM = 1'b0;
      ref_reset();
      @(negedge clk);
      rst_n = 1'b1;
      do_load(32'h48);

      // reset in the middle of a write (memory word not yet committed here)
      @(posedge clk); #1;
      ALUOutM    = 32'h48;
      WriteDataM = 32'hCAFE_0001;
      MemWriteM  = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rw_memwrite", {31'd0, MemWrite}, 32'd0);
      check("rw_stall", {31'd0, StallM}, 32'd0);
      check("rw_hitcnt", HitCount, 32'd0);
      check("rw_misscnt", MissCount, 32'd0);
      MemWriteM = 1'b0;
      ref_reset();
      @(negedge clk);
      rst_n = 1'b1;
      do_load(32'h48);

      // randomized mix of loads, stores and flushes
      for (int n = 0; n < 60; n++) begin
         int          op;
         logic [31:0] a;
         op = $urandom_range(0, 9);
         a  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         if (op == 0) begin
            do_flush();
         end else if (op <= 3) begin
            do_store(a, $urandom, 1'b0);
         end else begin
            do_load(a);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
